l2_cache_control: RTL and testbench



---
 rtl/l2_cache_control.sv | 140 ++++++++++++++
 tb/tb_l2_cache_control.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/l2_cache_control.sv
// Control FSM for a 2-way set-associative L2 cache with 256-bit lines.
// Sequences tag compare, hit response, dirty-victim writeback and line
// allocate, and drives the L2 datapath strobes. Keeps saturating hit/miss
// performance counters.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   mem_read, mem_write, mem_resp L1-side line request / completion pulse
//   pmem_read, pmem_write,
//   pmem_resp                     physical memory request / completion pulse
//   hit1, hit2, dirty1, dirty2,
//   lru                           per-set status from the datapath arrays
//   ld_way1, ld_way2, data_sel,
//   dirty_in, lru_ld, lru_in,
//   pmem_addr_sel                 datapath load/select strobes
//   hit_count, miss_count         saturating performance counters
module l2_cache_control #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic             mem_resp,
  output logic             pmem_read,
  output logic             pmem_write,
  input  logic             pmem_resp,
  input  logic             hit1,
  input  logic             hit2,
  input  logic             dirty1,
  input  logic             dirty2,
  input  logic             lru,
  output logic             ld_way1,
  output logic             ld_way2,
  output logic             data_sel,
  output logic             dirty_in,
  output logic             lru_ld,
  output logic             lru_in,
  output logic [1:0]       pmem_addr_sel,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  typedef enum logic [1:0] {
    StIdle,
    StCompare,
    StWriteback,
    StAllocate
  } state_e;

  state_e           state_q, state_d;
  logic             victim_q, victim_d;
  logic [CNT_W-1:0] hit_count_q, miss_count_q;
  logic             hit_inc, miss_inc;

  always_comb begin
    state_d       = state_q;
    victim_d      = victim_q;
    hit_inc       = 1'b0;
    miss_inc      = 1'b0;
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    ld_way1       = 1'b0;
    ld_way2       = 1'b0;
    data_sel      = 1'b0;
    dirty_in      = 1'b0;
    lru_ld        = 1'b0;
    lru_in        = 1'b0;
    pmem_addr_sel = 2'd0;

    unique case (state_q)
      StIdle: begin
        if (mem_read || mem_write) state_d = StCompare;
      end

      StCompare: begin
        if (!(mem_read || mem_write)) begin
          // Request dropped during a miss: the fill is done, just go home.
          state_d = StIdle;
        end else if (hit1 || hit2) begin
          mem_resp = 1'b1;
          lru_ld   = 1'b1;
          // Way 1 wins if both report a hit; the other way becomes victim.
          lru_in   = hit1;
          hit_inc  = 1'b1;
          if (mem_write) begin
            ld_way1  = hit1;
            ld_way2  = !hit1;
            data_sel = 1'b0;
            dirty_in = 1'b1;
          end
          state_d = StIdle;
        end else begin
          victim_d = lru;
          miss_inc = 1'b1;
          state_d  = (lru ? dirty2 : dirty1) ? StWriteback : StAllocate;
        end
      end

      StWriteback: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = victim_q ? 2'd2 : 2'd1;
        if (pmem_resp) state_d = StAllocate;
      end

      StAllocate: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          // Fill the registered victim; later LRU changes cannot redirect it.
          ld_way1  = !victim_q;
          ld_way2  = victim_q;
          data_sel = 1'b1;
          dirty_in = 1'b0;
          state_d  = StCompare;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      victim_q     <= 1'b0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      if (hit_inc && (hit_count_q != '1)) hit_count_q <= hit_count_q + 1'b1;
      if (miss_inc && (miss_count_q != '1)) miss_count_q <= miss_count_q + 1'b1;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_l2_cache_control.sv
module tb_l2_cache_control;

  localparam int unsigned CNT_W = 2;

  logic             clk;
  logic             rst_n;
  logic             mem_read, mem_write, mem_resp;
  logic             pmem_read, pmem_write, pmem_resp;
  logic             hit1, hit2, dirty1, dirty2, lru;
  logic             ld_way1, ld_way2, data_sel, dirty_in, lru_ld, lru_in;
  logic [1:0]       pmem_addr_sel;
  logic [CNT_W-1:0] hit_count, miss_count;

  l2_cache_control #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_resp     (mem_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_resp    (pmem_resp),
    .hit1         (hit1),
    .hit2         (hit2),
    .dirty1       (dirty1),
    .dirty2       (dirty2),
    .lru          (lru),
    .ld_way1      (ld_way1),
    .ld_way2      (ld_way2),
    .data_sel     (data_sel),
    .dirty_in     (dirty_in),
    .lru_ld       (lru_ld),
    .lru_in       (lru_in),
    .pmem_addr_sel(pmem_addr_sel),
    .hit_count    (hit_count),
    .miss_count   (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed vector: {resp, pread, pwrite, ld1, ld2, dsel, din, lru_ld, lru_in, asel, hit, miss}
  logic [14:0] obs;
  assign obs = {mem_resp, pmem_read, pmem_write, ld_way1, ld_way2, data_sel, dirty_in,
                lru_ld, lru_in, pmem_addr_sel, hit_count, miss_count};

  typedef struct {
    string       tag;
    logic [14:0] exp;
  } sb_entry_t;

  sb_entry_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [14:0] got, input logic [14:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] ev(input logic resp, pr, pw, l1, l2, ds, di, ll, li,
                                     input logic [1:0] as, hc, mc);
    return {resp, pr, pw, l1, l2, ds, di, ll, li, as, hc, mc};
  endfunction

  function automatic logic [14:0] idle_v(input logic [1:0] hc, mc);
    return {13'd0, hc, mc} | 15'd0 | {11'd0, hc, mc};
  endfunction

  function automatic logic [7:0] in_v(input logic rd, wr, h1, h2, d1, d2, l, pr);
    return {rd, wr, h1, h2, d1, d2, l, pr};
  endfunction

  // Drive one cycle of inputs and queue the outputs they must produce.
  task automatic cyc(input string tag, input logic [7:0] in, input logic [14:0] exp);
    @(posedge clk);
    #1;
    {mem_read, mem_write, hit1, hit2, dirty1, dirty2, lru, pmem_resp} = in;
    sb.push_back('{tag: tag, exp: exp});
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    {mem_read, mem_write, hit1, hit2, dirty1, dirty2, lru, pmem_resp} = 8'd0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      sb_entry_t e;
      e = sb.pop_front();
      check(e.tag, obs, e.exp);
    end
  end

  initial begin
    rst_n = 1'b0;
    {mem_read, mem_write, hit1, hit2, dirty1, dirty2, lru, pmem_resp} = 8'd0;
    #2;
    check("reset_outputs", obs, 15'd0);
    #10;
    rst_n = 1'b1;

    // Read hit on way 1
    cyc("rh_idle", in_v(1, 0, 0, 0, 0, 0, 0, 0), idle_v(0, 0));
    cyc("rh_cmp",  in_v(1, 0, 1, 0, 0, 0, 0, 0), ev(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    cyc("rh_done", in_v(0, 0, 0, 0, 0, 0, 0, 0), idle_v(1, 0));

    // Write hit on way 2
    cyc("wh_idle", in_v(0, 1, 0, 0, 0, 0, 0, 0), idle_v(1, 0));
    cyc("wh_cmp",  in_v(0, 1, 0, 1, 0, 0, 0, 0), ev(1, 0, 0, 0, 1, 0, 1, 1, 0, 0, 1, 0));
    cyc("wh_done", in_v(0, 0, 0, 0, 0, 0, 0, 0), idle_v(2, 0));

    // Clean miss, victim way 2, memory answers on the fifth allocate cycle
    do_reset();
    cyc("cm_idle", in_v(1, 0, 0, 0, 0, 0, 1, 0), idle_v(0, 0));
    cyc("cm_cmp",  in_v(1, 0, 0, 0, 0, 0, 1, 0), idle_v(0, 0));
    for (int k = 0; k < 4; k++) begin
      cyc("cm_alloc", in_v(1, 0, 0, 0, 0, 0, 1, 0), ev(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    end
    cyc("cm_fill",  in_v(1, 0, 0, 0, 0, 0, 1, 1), ev(0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1));
    cyc("cm_retry", in_v(1, 0, 0, 1, 0, 0, 0, 0), ev(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
    cyc("cm_done",  in_v(0, 0, 0, 0, 0, 0, 0, 0), idle_v(1, 1));

    // Dirty write miss, victim way 1; lru toggles mid-miss
    do_reset();
    cyc("dm_idle", in_v(0, 1, 0, 0, 1, 0, 0, 0), idle_v(0, 0));
    cyc("dm_cmp",  in_v(0, 1, 0, 0, 1, 0, 0, 0), idle_v(0, 0));
    cyc("dm_wb0",  in_v(0, 1, 0, 0, 1, 0, 1, 0), ev(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    cyc("dm_wb1",  in_v(0, 1, 0, 0, 1, 0, 0, 0), ev(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    cyc("dm_wb2",  in_v(0, 1, 0, 0, 1, 1, 1, 1), ev(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    cyc("dm_alc",  in_v(0, 1, 0, 0, 1, 1, 1, 0), ev(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    cyc("dm_fill", in_v(0, 1, 0, 0, 1, 1, 1, 1), ev(0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1));
    cyc("dm_hit",  in_v(0, 1, 1, 0, 0, 0, 1, 0), ev(1, 0, 0, 1, 0, 0, 1, 1, 1, 0, 0, 1));
    cyc("dm_done", in_v(0, 0, 0, 0, 0, 0, 0, 0), idle_v(1, 1));

    // Asynchronous reset while allocating
    cyc("ra_idle", in_v(1, 0, 0, 0, 0, 0, 0, 0), idle_v(1, 1));
    cyc("ra_cmp",  in_v(1, 0, 0, 0, 0, 0, 0, 0), idle_v(1, 1));
    cyc("ra_alc",  in_v(1, 0, 0, 0, 0, 0, 0, 0), ev(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2));
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("ra_async_pread", {14'd0, pmem_read}, 15'd0);
    check("ra_async_all", obs, 15'd0);
    {mem_read, mem_write, hit1, hit2, dirty1, dirty2, lru, pmem_resp} = 8'd0;
    #1;
    rst_n = 1'b1;
    cyc("ra_after", in_v(0, 0, 0, 0, 0, 0, 0, 0), idle_v(0, 0));
    cyc("ra_req",   in_v(1, 0, 1, 0, 0, 0, 0, 0), idle_v(0, 0));
    cyc("ra_hit",   in_v(1, 0, 1, 0, 0, 0, 0, 0), ev(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));

    // Hit counter saturation
    do_reset();
    for (int k = 0; k < 6; k++) begin
      logic [1:0] hc;
      hc = (k > 3) ? 2'd3 : 2'(k);
      cyc("sat_idle", in_v(1, 0, 1, 0, 0, 0, 0, 0), idle_v(hc, 0));
      cyc("sat_hit",  in_v(1, 0, 1, 0, 0, 0, 0, 0), ev(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, hc, 0));
    end
    cyc("sat_final", in_v(0, 0, 0, 0, 0, 0, 0, 0), idle_v(3, 0));

    @(posedge clk);
    @(posedge clk);
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
